// File: rtl/uart_rx_fifo_if.sv
// Byte-stream handshake between the UART receiver FIFO and its consumer.
// The receiver drives data/valid through the master modport; the consumer
// drives ready through the slave modport.
`timescale 1ns/1ps
interface uart_rx_fifo_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver: 16x oversampling with a 3-sample majority vote per bit,
// optional parity, sticky line-error flags and a first-word-fall-through
// receive FIFO presented as a valid/ready byte stream.
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    uart_rx_fifo_if.master                m,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun_err,
    input  logic                          err_clear
);

    localparam int unsigned CLKS_PER_TICK = CLK_FREQ / (BAUD_RATE * 16);
    localparam int unsigned TW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_TICK - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic          HAS_PAR   = (PARITY_EN != 0);
    localparam logic          ODD       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic          sync1_q, sync1_d;
    logic          rxs_q, rxs_d;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]    phase_q, phase_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    data_q, data_d;
    logic          s7_q, s7_d;
    logic          s8_q, s8_d;
    logic          pmis_q, pmis_d;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          fe_q, fe_d;
    logic          pe_q, pe_d;
    logic          ov_q, ov_d;

    logic          tick;
    logic          mid;
    logic          last;
    logic          maj;
    logic          push_req;
    logic          set_fe;
    logic          set_pe;
    logic          pop;
    logic          push_ok;

    // ------------------------------------------------------------------
    // Two-flop synchronizer for the asynchronous line
    // ------------------------------------------------------------------
    always_comb begin
        sync1_d = rx;
        rxs_d   = sync1_q;
    end

    // Synchronizer flops idle high so reset never looks like a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            rxs_q   <= rxs_d;
        end
    end

    // ------------------------------------------------------------------
    // Oversampling timebase and frame decoder
    // ------------------------------------------------------------------
    assign tick = (tick_cnt_q == TICK_LAST);
    assign mid  = tick && (phase_q == 4'd9);
    assign last = tick && (phase_q == 4'd15);
    // Samples from phases 7 and 8 are held; the phase-9 sample is live.
    assign maj  = (s7_q & s8_q) | (s7_q & rxs_q) | (s8_q & rxs_q);

    // Next-state logic for the timebase, bit sampling and frame FSM
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        phase_d    = tick ? phase_q + 4'd1 : phase_q;
        idx_d      = idx_q;
        data_d     = data_q;
        s7_d       = (tick && phase_q == 4'd7) ? rxs_q : s7_q;
        s8_d       = (tick && phase_q == 4'd8) ? rxs_q : s8_q;
        pmis_d     = pmis_q;
        push_req   = 1'b0;
        set_fe     = 1'b0;
        set_pe     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    // Realign the bit grid to the start edge.
                    state_d    = START;
                    tick_cnt_d = '0;
                    phase_d    = '0;
                    pmis_d     = 1'b0;
                end
            end
            START: begin
                if (mid && maj) begin
                    state_d = IDLE;
                end else if (last) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (mid) begin
                    data_d[idx_q] = maj;
                end
                if (last) begin
                    if (idx_q == 3'd7) begin
                        state_d = HAS_PAR ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (mid) begin
                    pmis_d = (maj != ((^data_q) ^ ODD));
                end
                if (last) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // Leave at mid-bit so a back-to-back start edge is caught.
                if (mid) begin
                    if (!maj) begin
                        set_fe  = 1'b1;
                        state_d = BREAK;
                    end else if (pmis_q) begin
                        set_pe  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        push_req = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            BREAK: begin
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Frame decoder state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            phase_q    <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            s7_q       <= 1'b1;
            s8_q       <= 1'b1;
            pmis_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            s7_q       <= s7_d;
            s8_q       <= s8_d;
            pmis_q     <= pmis_d;
        end
    end

    // ------------------------------------------------------------------
    // First-word-fall-through receive FIFO
    // ------------------------------------------------------------------
    assign pop     = (count_q != '0) && m.m_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push_ok = push_req && ((count_q != DEPTH_C) || pop);

    // Next-state logic for storage, pointers and occupancy
    always_comb begin
        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_q;
        end
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage and pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags: a new set in the clear cycle wins
    // ------------------------------------------------------------------
    always_comb begin
        fe_d = set_fe | (fe_q & ~err_clear);
        pe_d = set_pe | (pe_q & ~err_clear);
        ov_d = (push_req & ~push_ok) | (ov_q & ~err_clear);
    end

    // Sticky flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fe_q <= 1'b0;
            pe_q <= 1'b0;
            ov_q <= 1'b0;
        end else begin
            fe_q <= fe_d;
            pe_q <= pe_d;
            ov_q <= ov_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign m.m_data    = mem_q[rd_ptr_q];
    assign m.m_valid   = (count_q != '0);
    assign fifo_count  = count_q;
    assign frame_err   = fe_q;
    assign parity_err  = pe_q;
    assign overrun_err = ov_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: an 8N1 instance checked against a
// queue-based receive model, and an even-parity instance driven from a
// table of frames with hand-derived outcomes.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int BIT_CLKS = 64;
    localparam int DEPTH    = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx0, rx1;
    logic       ec0, ec1;
    logic [4:0] count0, count1;
    logic       fe0, pe0, ov0;
    logic       fe1, pe1, ov1;

    uart_rx_fifo_if m0 ();
    uart_rx_fifo_if m1 ();

    uart_rx_fifo #(
        .CLK_FREQ  (3_200_000),
        .BAUD_RATE (50_000),
        .PARITY_EN (0),
        .PARITY_ODD(0),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx0),
        .m          (m0),
        .fifo_count (count0),
        .frame_err  (fe0),
        .parity_err (pe0),
        .overrun_err(ov0),
        .err_clear  (ec0)
    );

    uart_rx_fifo #(
        .CLK_FREQ  (3_200_000),
        .BAUD_RATE (50_000),
        .PARITY_EN (1),
        .PARITY_ODD(0),
        .FIFO_DEPTH(DEPTH)
    ) dut_par (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx1),
        .m          (m1),
        .fifo_count (count1),
        .frame_err  (fe1),
        .parity_err (pe1),
        .overrun_err(ov1),
        .err_clear  (ec1)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model for the 8N1 instance: bytes expected out, in order.
    logic [7:0] exp_q[$];
    logic       exp_fe = 1'b0;
    logic       exp_ov = 1'b0;

    typedef struct packed {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       exp_push;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input bit sel, input logic v);
        if (sel) rx1 = v; else rx0 = v;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    // Sends one frame; for the 8N1 instance the model decides the outcome
    // just before the stop bit goes out.
    task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                              input bit par, input bit stop);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (has_par) drive_bit(sel, par);
        if (!sel) begin
            if (stop) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(d);
                else exp_ov = 1'b1;
            end else begin
                exp_fe = 1'b1;
            end
        end
        drive_bit(sel, stop);
        if (sel) rx1 = 1'b1; else rx0 = 1'b1;
    endtask

    task automatic pulse_clear0();
        ec0 = 1'b1;
        @(posedge clk);
        #1 ec0 = 1'b0;
    endtask

    // Every accepted pop on the 8N1 instance must match the model head.
    always @(negedge clk) begin
        if (!rst && m0.m_valid && m0.m_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL pop_unexpected: got %0h with model queue empty", m0.m_data);
            end else begin
                chk("pop_data", m0.m_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] d;
        bit         bad;
        bit         sending;
        int         cyc;

        // parity instance: even parity, bit value listed explicitly
        tbl[0] = '{data:8'h07, par:1'b1, stop:1'b1, exp_push:1'b1, exp_fe:1'b0, exp_pe:1'b0};
        tbl[1] = '{data:8'h07, par:1'b0, stop:1'b1, exp_push:1'b0, exp_fe:1'b0, exp_pe:1'b1};
        tbl[2] = '{data:8'h00, par:1'b0, stop:1'b1, exp_push:1'b1, exp_fe:1'b0, exp_pe:1'b0};
        tbl[3] = '{data:8'hFF, par:1'b0, stop:1'b1, exp_push:1'b1, exp_fe:1'b0, exp_pe:1'b0};
        tbl[4] = '{data:8'hFF, par:1'b1, stop:1'b1, exp_push:1'b0, exp_fe:1'b0, exp_pe:1'b1};
        tbl[5] = '{data:8'h80, par:1'b1, stop:1'b1, exp_push:1'b1, exp_fe:1'b0, exp_pe:1'b0};
        tbl[6] = '{data:8'h3C, par:1'b0, stop:1'b0, exp_push:1'b0, exp_fe:1'b1, exp_pe:1'b0};
        tbl[7] = '{data:8'h01, par:1'b0, stop:1'b0, exp_push:1'b0, exp_fe:1'b1, exp_pe:1'b0};

        rst = 1'b1;
        rx0 = 1'b1;
        rx1 = 1'b1;
        ec0 = 1'b0;
        ec1 = 1'b0;
        m0.m_ready = 1'b0;
        m1.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", m0.m_valid, 0);
        chk("rst_data", m0.m_data, 0);
        chk("rst_count", count0, 0);
        chk("rst_fe", fe0, 0);
        chk("rst_pe", pe0, 0);
        chk("rst_ov", ov0, 0);
        chk("rst_count_par", count1, 0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // ---- single byte and latency ----
        m0.m_ready = 1'b1;
        cyc = 0;
        fork
            send_frame(0, 8'hA5, 0, 0, 1);
            begin
                while (!m0.m_valid && cyc < 800) begin
                    @(negedge clk);
                    cyc++;
                end
                chk("latency_in_window", (cyc >= 610 && cyc <= 630), 1);
                @(negedge clk);
                chk("valid_one_cycle", m0.m_valid, 0);
            end
        join
        repeat (20) @(posedge clk);
        #1;
        chk("a5_consumed", exp_q.size(), 0);
        chk("a5_fe", fe0, 0);

        // ---- glitch rejection ----
        rx0 = 1'b0;
        repeat (20) @(posedge clk);
        #1 rx0 = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        chk("glitch_count", count0, 0);
        chk("glitch_fe", fe0, 0);
        send_frame(0, 8'h5A, 0, 0, 1);
        repeat (40) @(posedge clk);
        #1;
        chk("after_glitch_rx", exp_q.size(), 0);

        // ---- framing error and break ----
        send_frame(0, 8'h3C, 0, 0, 0);
        rx0 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("fe_set", fe0, 1);
        chk("fe_count", count0, 0);
        pulse_clear0();
        exp_fe = 1'b0;
        chk("fe_cleared", fe0, 0);
        repeat (3 * BIT_CLKS - 11) @(posedge clk);
        #1 rx0 = 1'b1;
        repeat (70) @(posedge clk);
        #1;
        chk("fe_once", fe0, 0);
        send_frame(0, 8'h55, 0, 0, 1);
        repeat (40) @(posedge clk);
        #1;
        chk("after_break_rx", exp_q.size(), 0);

        // ---- overrun and wrap ----
        m0.m_ready = 1'b0;
        for (int b = 0; b < 17; b++) send_frame(0, 8'(b), 0, 0, 1);
        repeat (20) @(posedge clk);
        #1;
        chk("full_count", count0, 16);
        chk("overrun_set", ov0, exp_ov);
        for (int k = 0; k < 4; k++) begin
            chk("head_stable", m0.m_data, 8'h00);
            @(posedge clk);
            #1;
        end
        m0.m_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("drained_model", exp_q.size(), 0);
        chk("drained_count", count0, 0);
        pulse_clear0();
        exp_ov = 1'b0;
        chk("overrun_cleared", ov0, 0);
        sending = 1'b1;
        fork
            begin
                for (int n = 0; n < 20; n++) send_frame(0, 8'($urandom_range(0, 255)), 0, 0, 1);
                sending = 1'b0;
            end
            while (sending) begin
                @(posedge clk);
                #1 m0.m_ready = 1'($urandom_range(0, 1));
            end
        join
        m0.m_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("wrap_drained", exp_q.size(), 0);
        chk("wrap_no_overrun", ov0, 0);

        // ---- reset mid-frame ----
        m0.m_ready = 1'b0;
        send_frame(0, 8'h11, 0, 0, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("pre_rst_count", count0, 1);
        d = 8'hC3;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, d[i]);
        rx0 = d[4];
        repeat (BIT_CLKS / 2) @(posedge clk);
        #1 rst = 1'b1;
        #2;
        chk("midrst_valid", m0.m_valid, 0);
        chk("midrst_count", count0, 0);
        chk("midrst_data", m0.m_data, 0);
        chk("midrst_fe", fe0, 0);
        exp_q.delete();
        rx0 = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1 m0.m_ready = 1'b1;
        send_frame(0, 8'hC3, 0, 0, 1);
        repeat (40) @(posedge clk);
        #1;
        chk("c3_received", exp_q.size(), 0);

        // ---- randomized frames against the model ----
        pulse_clear0();
        exp_fe = 1'b0;
        sending = 1'b1;
        fork
            begin
                for (int n = 0; n < 30; n++) begin
                    d   = 8'($urandom_range(0, 255));
                    bad = ($urandom_range(0, 5) == 0);
                    send_frame(0, d, 0, 0, !bad);
                    if (bad || ($urandom_range(0, 1) == 1)) drive_bit(0, 1'b1);
                end
                sending = 1'b0;
            end
            while (sending) begin
                @(posedge clk);
                #1 m0.m_ready = 1'($urandom_range(0, 1));
            end
        join
        m0.m_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_fe", fe0, exp_fe);
        chk("rand_ov", ov0, exp_ov);
        chk("rand_pe", pe0, 0);

        // ---- parity instance, table driven ----
        for (int t = 0; t < 8; t++) begin
            ec1 = 1'b1;
            @(posedge clk);
            #1 ec1 = 1'b0;
            chk("par_clr_pe", pe1, 0);
            chk("par_clr_fe", fe1, 0);
            send_frame(1, tbl[t].data, 1, tbl[t].par, tbl[t].stop);
            repeat (8) @(posedge clk);
            #1;
            chk("par_count", count1, 5'(tbl[t].exp_push));
            chk("par_fe", fe1, tbl[t].exp_fe);
            chk("par_pe", pe1, tbl[t].exp_pe);
            if (tbl[t].exp_push) chk("par_data", m1.m_data, tbl[t].data);
            if (count1 != 0) begin
                m1.m_ready = 1'b1;
                @(posedge clk);
                #1 m1.m_ready = 1'b0;
                chk("par_popped", count1, 0);
            end
        end
        ec1 = 1'b1;
        @(posedge clk);
        #1 ec1 = 1'b0;
        chk("par_final_clear", fe1, 0);
        chk("par_ov", ov1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Standalone UART receive engine with 16x oversampling, 3-sample majority voting, optional parity, and a first-word-fall-through receive FIFO with a valid/ready output. It is the receiving end for frames produced by the team's UART transmitter: 1 start bit, 8 data bits LSB first, optional parity bit, and 1 stop bit. It sits between the pad-side RX line and a byte-stream consumer, such as a command parser or DMA. Line errors are reported as sticky flags.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: line rate in bit/s. CLKS_PER_TICK = CLK_FREQ/(BAUD_RATE*16), integer division, must be ≥1.
- PARITY_EN, 0: 1 inserts a parity bit between data bit 7 and the stop bit.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd. Ignored when PARITY_EN=0.
- FIFO_DEPTH, 16: number of entries. Power of two, ≥2.
- clk  input  1  system clock.
- rst  input  1  reset. One clock; reset is asynchronous and active-high.
- rx  input  1  asynchronous serial line. Idles high.
- m_data  output  8  byte at the FIFO head.
- m_valid  output  1  FIFO non-empty.
- m_ready  input  1  consumer accepts m_data.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of stored entries.
- frame_err  output  1  sticky: a stop bit was sampled low.
- parity_err  output  1  sticky: a parity mismatch occurred.
- overrun_err  output  1  sticky: a good byte arrived while the FIFO was full.
- err_clear  input  1  single-cycle pulse that clears all three sticky flags.

## Operation
- **Synchronizer:** rx passes through a 2-flop synchronizer with reset value 1. All logic uses the synchronized value rxs.
- **Tick generator:** a counter pulses `tick` once every CLKS_PER_TICK clocks. The tick counter and a 4-bit `phase` counter (0..15) are both forced to 0 in the cycle a start edge is detected.
- **Majority sampling:** each bit is sampled at phase 7, 8 and 9. The bit value is the majority of the three samples and is decided at phase 9. The bit period ends at phase 15.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: rxs==0 → START.
  - START: majority==1 at phase 9 → IDLE. This is a glitch; no flag is set. Otherwise, at phase 15 → DATA with bit index 0.
  - DATA: the majority bit is shifted into data bit[index]. At phase 15, index==7 → PARITY if PARITY_EN, else STOP. Otherwise index increments.
  - PARITY: at phase 9, compute the mismatch, where expected = (^data) ^ PARITY_ODD. At phase 15 → STOP.
  - STOP: all decisions are made at phase 9, and the block leaves STOP at phase 9, half a bit early, so a back-to-back start edge is never missed.
    - Stop bit 0 → set frame_err, drop the byte, → BREAK.
    - Stop bit 1 with a parity mismatch → set parity_err, drop the byte, → IDLE.
    - Stop bit 1 with no mismatch → push the byte, → IDLE.
  - BREAK: wait for rxs==1, then → IDLE. A held-low line produces exactly one frame_err.
- **Push rule:** a push succeeds if fifo_count<FIFO_DEPTH, or if a pop happens in the same cycle. Otherwise the byte is dropped, overrun_err is set, and FIFO contents are unchanged.
- **FIFO:**
  - First-word-fall-through: m_data = mem[rd_ptr] and m_valid = (fifo_count!=0).
  - A pop occurs when m_valid && m_ready.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally.
- **Sticky flags:** each flag stays set until err_clear. If err_clear and a new set of the same flag occur in the same cycle, the set wins.
- **Reset mid-frame:** the frame is abandoned, the FSM goes to IDLE, and the FIFO empties. A line still low after reset is decoded as a start bit once the synchronizer has refilled.

## Timing
- **Reset values:**
  - m_data=0; FIFO storage is reset to 0.
  - m_valid=0, fifo_count=0.
  - frame_err=0, parity_err=0, overrun_err=0.
  - FSM in IDLE; synchronizer flops at 1.
- **Start detection latency:** 2 clocks from the rx falling edge to the START entry (synchronizer delay).
- **Bit period:** 16 ticks = 16*CLKS_PER_TICK clocks.
- **Byte latency:** the push is registered on the phase-9 tick of the stop bit. m_valid rises and fifo_count increments on the next clock edge. Flags follow the same timing.
- **Pop:** an accepted pop updates m_data and fifo_count on the following edge. m_data is stable while m_valid=1 and m_ready=0.
- **Throughput:** the block sustains back-to-back frames with zero idle bits.

## Test plan
All scenarios use CLK_FREQ=3_200_000 and BAUD_RATE=50_000, giving 4 clk/tick and 64 clk/bit.
- **Single byte:** drive 0xA5, 8N1, with m_ready=1 → m_data=0xA5 with m_valid high for one cycle, 2+9*64+37 clocks (approx.) after the start edge. No flags set.
- **Glitch rejection:** drive a 20-clock low pulse → no byte pushed, no flag set, FSM back in IDLE.
- **Framing error and break:** drive 0x3C with the stop bit low, then hold the line low for 3 bit times → frame_err=1 exactly once and fifo_count=0. Then send 0x55 → 0x55 is received normally.
- **Parity:** with PARITY_EN=1 and PARITY_ODD=0, send 0x07 with parity bit 1 → accepted. Send 0x07 with parity bit 0 → parity_err=1 and the byte is dropped. Pulse err_clear → parity_err=0.
- **Overrun and wrap:** hold m_ready=0 and send 17 back-to-back bytes 0x00..0x10 → fifo_count=16 and overrun_err=1. Drain → bytes 0x00..0x0F in order. Send 20 more bytes while draining → order is preserved across the pointer wrap.
- **Reset mid-frame:** assert rst during data bit 4 → all outputs return to their reset values immediately. Release rst → the next full frame (0xC3) is received correctly.
